// File: rtl/serial_operand_feeder.sv
// Serialises parallel operand pairs LSB-first onto a serial adder's a/b inputs.
// A one-entry pending buffer lets the next pair follow with no idle cycle between frames.
module serial_operand_feeder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             carryin,
    output logic             ser_valid,
    output logic             ser_start,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent,
    output logic             state_dbg
);

    // Handshake: a pair transfers on any rising edge where in_valid and in_ready
    // are both high; in_ready depends only on the pending buffer, never on in_valid.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] act_a_q, act_a_d;
    logic [WIDTH-1:0] act_b_q, act_b_d;
    logic [WIDTH-1:0] pend_a_q, pend_a_d;
    logic [WIDTH-1:0] pend_b_q, pend_b_d;
    logic             pend_cin_q, pend_cin_d;
    logic             pend_full_q, pend_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carryin_q, carryin_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             last_q, last_d;
    logic             xfer;
    logic             live;

    assign xfer = in_valid & ~pend_full_q;

    always_comb begin
        state_d     = state_q;
        act_a_d     = act_a_q;
        act_b_d     = act_b_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        pend_cin_d  = pend_cin_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;
        carryin_d   = carryin_q;
        frames_d    = frames_q;

        if (abort) begin
            state_d     = IDLE;
            pend_full_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        act_a_d   = op_a;
                        act_b_d   = op_b;
                        carryin_d = cin_in;
                        cnt_d     = '0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
                        frames_d = frames_q + CNT_W'(1);
                        cnt_d    = '0;
                        // Pending entry has priority; otherwise a same-edge transfer reloads directly.
                        if (pend_full_q) begin
                            act_a_d     = pend_a_q;
                            act_b_d     = pend_b_q;
                            carryin_d   = pend_cin_q;
                            pend_full_d = 1'b0;
                        end else if (xfer) begin
                            act_a_d   = op_a;
                            act_b_d   = op_b;
                            carryin_d = cin_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (xfer) begin
                            pend_a_d    = op_a;
                            pend_b_d    = op_b;
                            pend_cin_d  = cin_in;
                            pend_full_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        live    = (state_d == SHIFT);
        a_d     = live & act_a_d[cnt_d];
        b_d     = live & act_b_d[cnt_d];
        valid_d = live;
        start_d = live & (cnt_d == '0);
        last_d  = live & (cnt_d == LAST_BIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            act_a_q     <= '0;
            act_b_q     <= '0;
            pend_a_q    <= '0;
            pend_b_q    <= '0;
            pend_cin_q  <= 1'b0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            carryin_q   <= 1'b0;
            frames_q    <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_a_q     <= act_a_d;
            act_b_q     <= act_b_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            pend_cin_q  <= pend_cin_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
            carryin_q   <= carryin_d;
            frames_q    <= frames_d;
            a_q         <= a_d;
            b_q         <= b_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            last_q      <= last_d;
        end
    end

    assign in_ready    = ~pend_full_q;
    assign busy        = (state_q == SHIFT) | pend_full_q;
    assign a           = a_q;
    assign b           = b_q;
    assign carryin     = carryin_q;
    assign ser_valid   = valid_q;
    assign ser_start   = start_q;
    assign ser_last    = last_q;
    assign frames_sent = frames_q;
    assign state_dbg   = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: a frame queue predicts every serial bit,
// framing flag, carry-in, handshake and frame count.
module tb_serial_operand_feeder;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          cin_in = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          in_ready, a, b, carryin, ser_valid, ser_start, ser_last, busy, state_dbg;
    logic [CW-1:0] frames_sent;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame record {cin, b, a}; head is the frame currently on the serial lines.
    logic [2*W:0]  exp_q[$];
    int            bit_idx = 0;
    logic [CW-1:0] exp_frames = '0;
    logic          last_cin = 1'b0;

    serial_operand_feeder #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin_in(cin_in), .abort(abort),
        .a(a), .b(b), .carryin(carryin), .ser_valid(ser_valid),
        .ser_start(ser_start), .ser_last(ser_last), .busy(busy),
        .frames_sent(frames_sent), .state_dbg(state_dbg)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected-frame model, advanced on the same edges the DUT uses.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            bit_idx    = 0;
            exp_frames = '0;
            last_cin   = 1'b0;
        end else if (abort) begin
            exp_q.delete();
            bit_idx = 0;
        end else begin
            logic acc;
            acc = in_valid && (exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                if (bit_idx == W - 1) begin
                    void'(exp_q.pop_front());
                    bit_idx    = 0;
                    exp_frames = exp_frames + 1'b1;
                end else begin
                    bit_idx++;
                end
            end
            if (acc) exp_q.push_back({cin_in, op_b, op_a});
        end
    end

    always @(negedge clk) begin
        logic [2*W:0] f;
        if (rst) begin
            check("frames_sent", frames_sent, exp_frames);
            check("ser_valid", ser_valid, exp_q.size() != 0);
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                check("a_bit", a, f[bit_idx]);
                check("b_bit", b, f[W + bit_idx]);
                check("carryin", carryin, f[2*W]);
                check("ser_start", ser_start, bit_idx == 0);
                check("ser_last", ser_last, bit_idx == W - 1);
                last_cin = f[2*W];
            end else begin
                check("idle_a", a, 1'b0);
                check("idle_b", b, 1'b0);
                check("idle_start", ser_start, 1'b0);
                check("idle_last", ser_last, 1'b0);
                check("idle_carryin", carryin, last_cin);
            end
        end
    end

    // Offers a pair and returns at the falling edge after it was accepted; in_valid stays high.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int n = 0;
        op_a = va; op_b = vb; cin_in = vc; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0]  oa, ob, y;
        logic          c;
        logic [CW-1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) @(negedge clk);
        check("rst_a", a, 1'b0);
        check("rst_b", b, 1'b0);
        check("rst_carryin", carryin, 1'b0);
        check("rst_valid", ser_valid, 1'b0);
        check("rst_start", ser_start, 1'b0);
        check("rst_last", ser_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frames", frames_sent, 0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_state", state_dbg, 1'b0);
        rst = 1'b1;

        // Single frame: 11 + 6 + 1 = 18
        send(4'b1011, 4'b0110, 1'b1);
        in_valid = 1'b0;
        check("t1_state", state_dbg, 1'b1);
        for (int i = 0; i < W; i++) begin
            oa[i] = a;
            ob[i] = b;
            check("t1_carryin", carryin, 1'b1);
            @(negedge clk);
        end
        check("t1_a_seq", oa, 4'b1011);
        check("t1_b_seq", ob, 4'b0110);
        c = 1'b1;
        for (int i = 0; i < W; i++) begin
            y[i] = oa[i] ^ ob[i] ^ c;
            c    = (oa[i] & ob[i]) | (c & (oa[i] ^ ob[i]));
        end
        check("t1_sum", y, 4'b0010);
        check("t1_cout", c, 1'b1);
        check("t1_frames", frames_sent, 1);
        check("t1_valid_low", ser_valid, 1'b0);

        // Back-to-back: second pair offered during bit 1
        send(4'b1011, 4'b0110, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        send(4'h3, 4'h4, 1'b0);
        in_valid = 1'b0;
        check("t2_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("t2_last", ser_last, 1'b1);
        check("t2_ready_low2", in_ready, 1'b0);
        check("t2_cin_old", carryin, 1'b1);
        @(negedge clk);
        check("t2_start", ser_start, 1'b1);
        check("t2_cin_new", carryin, 1'b0);
        check("t2_ready_back", in_ready, 1'b1);
        check("t2_frames_mid", frames_sent, 2);
        repeat (W) @(negedge clk);
        check("t2_frames", frames_sent, 3);

        // Backpressure: three pairs with in_valid held high
        send(4'h1, 4'h2, 1'b0);
        send(4'h5, 4'h6, 1'b1);
        check("t3_pend_full", in_ready, 1'b0);
        check("t3_busy", busy, 1'b1);
        send(4'h9, 4'hA, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("t3_frames", frames_sent, 2);

        // Abort at bit 2 with a pending entry
        send(4'hC, 4'h3, 1'b1);
        send(4'h7, 4'h8, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_valid", ser_valid, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_ready", in_ready, 1'b1);
        check("t4_frames", frames_sent, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_start", ser_start, 1'b0);
        end

        // A transfer on the same edge as abort is dropped
        abort = 1'b1;
        send(4'hF, 4'hF, 1'b1);
        abort = 1'b0;
        in_valid = 1'b0;
        check("t4b_valid", ser_valid, 1'b0);
        check("t4b_busy", busy, 1'b0);
        @(negedge clk);
        check("t4b_valid2", ser_valid, 1'b0);

        // Asynchronous reset mid-frame
        send(4'h6, 4'h9, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_a", a, 1'b0);
        check("t5_b", b, 1'b0);
        check("t5_carryin", carryin, 1'b0);
        check("t5_valid", ser_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_frames", frames_sent, 0);
        check("t5_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        send(4'b0101, 4'b0011, 1'b0);
        in_valid = 1'b0;
        check("t5_first_start", ser_start, 1'b1);
        check("t5_first_a", a, 1'b1);
        check("t5_first_b", b, 1'b1);
        wait_idle();
        check("t5_frames_after", frames_sent, 1);

        // Counter wrap from a clean reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(W'(k + 1), W'(k + 2), k[0]);
            in_valid = 1'b0;
            repeat (W) @(negedge clk);
            check("t6_wrap", frames_sent, wrap_exp[k]);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage of the 4-bit serial adder.
- Accepts parallel operand pairs (op_a, op_b, cin_in) on a valid/ready handshake and serialises them LSB-first onto the adder's a/b inputs, one bit per clock.
- Holds carryin constant for the whole frame and marks frame boundaries.
- A one-entry pending buffer lets the next operand pair follow back-to-back with no idle cycle between frames.

Parameters:
- WIDTH, 4: operand width in bits, equal to the serial frame length; WIDTH >= 2.
- CNT_W, 8: width of the frames_sent counter.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-low reset (asserts immediately when low, releases synchronously to clk).
- in_valid  input  1  Operand pair on op_a/op_b/cin_in is valid.
- in_ready  output  1  Feeder can accept; equals !pend_full (combinational).
- op_a  input  WIDTH  Parallel operand A.
- op_b  input  WIDTH  Parallel operand B.
- cin_in  input  1  Carry-in for this operand pair.
- abort  input  1  Synchronous flush of the active and pending frames.
- a  output  1  Serial bit of A, registered.
- b  output  1  Serial bit of B, registered.
- carryin  output  1  Frame carry-in, registered; constant across a frame.
- ser_valid  output  1  a/b carry a live bit this cycle.
- ser_start  output  1  High during bit 0 of a frame.
- ser_last  output  1  High during bit WIDTH-1 of a frame.
- busy  output  1  A frame is active or pending.
- frames_sent  output  CNT_W  Count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low):
  - State IDLE; shift registers, pending buffer and bit counter cleared.
  - a, b, carryin, ser_valid, ser_start, ser_last, busy and frames_sent are all 0.
  - in_ready = 1.
- FSM states: IDLE and SHIFT. Bit counter width is clog2(WIDTH) and counts 0..WIDTH-1.
- Handshake: a transfer occurs on a rising edge where in_valid & in_ready are both high. Operands are sampled on that edge only.
- IDLE + transfer at edge k:
  - Operands load into the active shift registers; state becomes SHIFT.
  - On the cycle after edge k: a = op_a[0], b = op_b[0], carryin = cin_in, ser_valid = 1, ser_start = 1.
  - Latency from transfer to first bit: 1 cycle.
- In SHIFT, each edge advances one bit: a/b present bit i during the cycle where the counter equals i. ser_last is high when counter = WIDTH-1.
- Transfer while in SHIFT and not on the last bit: operands go into the pending buffer; pend_full = 1, so in_ready = 0.
- End of the last bit (counter = WIDTH-1 at the edge):
  - frames_sent increments.
  - If pending is full: pending moves to active, pend_full clears, state stays SHIFT, and ser_start is high on the next cycle. Frames run back-to-back with 0 gap cycles.
  - Else, if a transfer happens on this same edge (pending is empty, so in_ready = 1): operands go directly into active. Back-to-back, 0 gap.
  - Else: state becomes IDLE; a, b, ser_valid, ser_start and ser_last all drop to 0; carryin holds its last value.
- carryin changes only at a frame start, never mid-frame.
- busy = (state == SHIFT) | pend_full.
- abort (sampled on the edge):
  - State goes to IDLE; pending is cleared; a/b/ser_* go to 0 on the next cycle.
  - frames_sent does not increment.
  - A transfer offered on the same edge as abort is discarded; abort wins.
- Reset mid-frame: outputs clear immediately (asynchronous); the partial frame is lost and is not counted.
- frames_sent wraps from 2^CNT_W-1 to 0.
- Downstream contract: the adder's rst is driven low before the first ser_start. With back-to-back frames, the adder's 2-bit counter stays aligned because WIDTH = 4.

Test Plan:
- Single frame, WIDTH=4, op_a=4'b1011, op_b=4'b0110, cin_in=1:
  - a = 1,1,0,1 and b = 0,1,1,0 over 4 cycles; carryin = 1 throughout.
  - ser_start on cycle 1, ser_last on cycle 4.
  - Downstream adder gives y = 4'b0010, carryout = 1 (11 + 6 + 1 = 18).
  - frames_sent = 1.
- Back-to-back: offer a second pair (op_a=4'h3, op_b=4'h4, cin_in=0) during bit 1 of frame 1:
  - in_ready drops to 0 until the pending entry drains.
  - ser_start for frame 2 comes on the cycle immediately after frame 1's ser_last.
  - carryin switches 1 -> 0 exactly at frame 2 bit 0.
- Backpressure: hold in_valid high with three distinct pairs:
  - Exactly one is accepted into active and one into pending; the third waits for in_ready.
  - All three are serialised in order with no gaps; frames_sent = 3.
- Abort at bit 2 with a pending entry present:
  - ser_valid = 0 and busy = 0 the next cycle; in_ready = 1.
  - frames_sent is unchanged; no ser_start follows.
- Asynchronous reset pulse mid-frame (between clock edges):
  - All outputs go to 0 immediately.
  - After release, a fresh transfer produces bit 0 exactly one cycle later.
- Wrap: CNT_W=2, run 5 frames -> frames_sent sequence 1, 2, 3, 0, 1.
